// File: rtl/wb_stage.sv
// wb_stage: writeback stage between the memory stage and the 32x32 register file.
//
// Accepts one retiring instruction per in_valid/in_ready handshake. Non-loads go
// straight to a one-cycle WRITE. Loads park in WAIT_MEM until mem_rdata_valid, then
// the addressed byte/halfword/word is extracted, extended and written one cycle later.
//
// Ports:
//   clk, rst           rising-edge clock; asynchronous active-high reset
//   in_valid/in_ready  handshake from the memory stage (in_ready = state != WAIT_MEM)
//   in_dest            destination register
//   in_result          ALU result for non-loads
//   in_is_load         instruction is a load
//   in_ld_type         000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu, 101..111 lw
//   in_addr_lo         load address bits [1:0]
//   mem_rdata_valid    data memory read data valid (only honoured in WAIT_MEM)
//   mem_rdata          data memory read word
//   wen/waddr/wdata    register file write port, registered
//   busy               stage is waiting on data memory
//   retire_cnt         retired-instruction counter, wraps at 2^CNT_W
//
// Optional feature (macro WB_BYPASS_EN):
//   byp_valid/byp_addr/byp_data mirror the write port during WRITE for decode-stage
//   forwarding; byp_valid is 0 outside WRITE and on reset.

module wb_stage #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_is_load,
  input  logic [2:0]        in_ld_type,
  input  logic [1:0]        in_addr_lo,
  input  logic              mem_rdata_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic [CNT_W-1:0]  retire_cnt
`ifdef WB_BYPASS_EN
  ,
  output logic              byp_valid,
  output logic [ADDR_W-1:0] byp_addr,
  output logic [DATA_W-1:0] byp_data
`endif
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWaitMem = 2'd1,
    StWrite   = 2'd2
  } state_t;

  localparam logic [2:0] LdLb  = 3'b001;
  localparam logic [2:0] LdLbu = 3'b010;
  localparam logic [2:0] LdLh  = 3'b011;
  localparam logic [2:0] LdLhu = 3'b100;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_dest;
  logic [2:0]          r_ld_type;
  logic [1:0]          r_addr_lo;
  logic                r_wen;
  logic [ADDR_W-1:0]   r_waddr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_busy;
  logic [CNT_W-1:0]    r_retire_cnt;

  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [DATA_W-1:0]   w_ld_data;

  // Lane select uses the latched address; addr_lo[0] is ignored for halfwords.
  always_comb begin
    w_byte = 8'h00;
    unique case (r_addr_lo)
      2'd0: w_byte = mem_rdata[7:0];
      2'd1: w_byte = mem_rdata[15:8];
      2'd2: w_byte = mem_rdata[23:16];
      2'd3: w_byte = mem_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  always_comb begin
    w_ld_data = mem_rdata;
    case (r_ld_type)
      LdLb:    w_ld_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      LdLbu:   w_ld_data = {{(DATA_W-8){1'b0}}, w_byte};
      LdLh:    w_ld_data = {{(DATA_W-16){w_half[15]}}, w_half};
      LdLhu:   w_ld_data = {{(DATA_W-16){1'b0}}, w_half};
      default: w_ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_dest       <= '0;
      r_ld_type    <= '0;
      r_addr_lo    <= '0;
      r_wen        <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_busy       <= 1'b0;
      r_retire_cnt <= '0;
    end else begin
      // wen is a one-cycle pulse; only the transitions into WRITE raise it.
      r_wen <= 1'b0;
      case (r_state)
        StIdle, StWrite: begin
          if (in_valid) begin
            if (in_is_load) begin
              r_dest    <= in_dest;
              r_ld_type <= in_ld_type;
              r_addr_lo <= in_addr_lo;
              r_busy    <= 1'b1;
              r_state   <= StWaitMem;
            end else begin
              r_wen        <= (in_dest != '0);
              r_waddr      <= in_dest;
              r_wdata      <= in_result;
              r_retire_cnt <= r_retire_cnt + CNT_W'(1);
              r_state      <= StWrite;
            end
          end else begin
            r_state <= StIdle;
          end
        end
        StWaitMem: begin
          if (mem_rdata_valid) begin
            r_wen        <= (r_dest != '0);
            r_waddr      <= r_dest;
            r_wdata      <= w_ld_data;
            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            r_busy       <= 1'b0;
            r_state      <= StWrite;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign in_ready   = (r_state != StWaitMem);
  assign wen        = r_wen;
  assign waddr      = r_waddr;
  assign wdata      = r_wdata;
  assign busy       = r_busy;
  assign retire_cnt = r_retire_cnt;

`ifdef WB_BYPASS_EN
  // wen is only ever high in WRITE, so it doubles as the bypass qualifier.
  assign byp_valid = r_wen;
  assign byp_addr  = r_waddr;
  assign byp_data  = r_wdata;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by random transactions,
// each checked against a transaction-level model of the writeback rules.
module tb_wb_stage;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 32;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_dest;
  logic [DATA_W-1:0] in_result;
  logic              in_is_load;
  logic [2:0]        in_ld_type;
  logic [1:0]        in_addr_lo;
  logic              mem_rdata_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic [CNT_W-1:0]  retire_cnt;
`ifdef WB_BYPASS_EN
  logic              byp_valid;
  logic [ADDR_W-1:0] byp_addr;
  logic [DATA_W-1:0] byp_data;
`endif

  wb_stage #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_dest        (in_dest),
    .in_result      (in_result),
    .in_is_load     (in_is_load),
    .in_ld_type     (in_ld_type),
    .in_addr_lo     (in_addr_lo),
    .mem_rdata_valid(mem_rdata_valid),
    .mem_rdata      (mem_rdata),
    .wen            (wen),
    .waddr          (waddr),
    .wdata          (wdata),
    .busy           (busy),
    .retire_cnt     (retire_cnt)
`ifdef WB_BYPASS_EN
    ,
    .byp_valid      (byp_valid),
    .byp_addr       (byp_addr),
    .byp_data       (byp_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: what the register-file port should show.
  int unsigned exp_cnt   = 0;
  int unsigned last_addr = 0;
  int unsigned last_data = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Load result from the extraction rules, written as plain shifts and masks.
  function automatic int unsigned ld_model(input int unsigned ld_type, input int unsigned addr,
                                           input int unsigned word);
    int unsigned b;
    int unsigned h;
    b = (word >> (8 * addr)) & 32'hFF;
    h = (word >> (16 * (addr / 2))) & 32'hFFFF;
    case (ld_type)
      1: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      2: return b;
      3: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      4: return h;
      default: return word;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Checks a cycle in which the instruction (dest, data) is being written.
  task automatic check_write(input string tag, input int unsigned dest, input int unsigned data);
    exp_cnt   = exp_cnt + 1;
    last_addr = dest;
    last_data = data;
    check({tag, ".wen"}, 64'(wen), 64'(dest != 0));
    check({tag, ".waddr"}, 64'(waddr), 64'(dest));
    check({tag, ".wdata"}, 64'(wdata), 64'(data));
    check({tag, ".cnt"}, 64'(retire_cnt), 64'(exp_cnt));
    check({tag, ".rdy"}, 64'(in_ready), 64'd1);
    check({tag, ".busy"}, 64'(busy), 64'd0);
`ifdef WB_BYPASS_EN
    check({tag, ".byp_v"}, 64'(byp_valid), 64'(wen));
    check({tag, ".byp_a"}, 64'(byp_addr), 64'(waddr));
    check({tag, ".byp_d"}, 64'(byp_data), 64'(wdata));
`endif
  endtask

  // Checks a cycle with no write in flight; port holds its last values.
  task automatic check_quiet(input string tag, input logic exp_busy);
    check({tag, ".wen"}, 64'(wen), 64'd0);
    check({tag, ".waddr"}, 64'(waddr), 64'(last_addr));
    check({tag, ".wdata"}, 64'(wdata), 64'(last_data));
    check({tag, ".cnt"}, 64'(retire_cnt), 64'(exp_cnt));
    check({tag, ".busy"}, 64'(busy), 64'(exp_busy));
    check({tag, ".rdy"}, 64'(in_ready), 64'(!exp_busy));
`ifdef WB_BYPASS_EN
    check({tag, ".byp_v"}, 64'(byp_valid), 64'd0);
`endif
  endtask

  // All tasks start and end at a negedge. in_valid is left high by send_alu so that
  // consecutive calls form back-to-back transfers.
  task automatic send_alu(input int unsigned dest, input int unsigned data);
    check("alu.ready", 64'(in_ready), 64'd1);
    in_valid   = 1'b1;
    in_is_load = 1'b0;
    in_dest    = ADDR_W'(dest);
    in_result  = data;
    in_ld_type = 3'($urandom_range(7));
    in_addr_lo = 2'($urandom_range(3));
    tick();
    check_write("alu", dest, data);
  endtask

  task automatic idle(input int n, input logic noise);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_rdata_valid = noise ? 1'b1 : 1'($urandom_range(1));
      mem_rdata       = $urandom;
      tick();
      check_quiet("idle", 1'b0);
    end
    mem_rdata_valid = 1'b0;
  endtask

  task automatic send_load(input int unsigned dest, input int unsigned ld_type,
                           input int unsigned addr, input int unsigned word, input int nwait);
    check("ld.ready", 64'(in_ready), 64'd1);
    in_valid        = 1'b1;
    in_is_load      = 1'b1;
    in_dest         = ADDR_W'(dest);
    in_ld_type      = 3'(ld_type);
    in_addr_lo      = 2'(addr);
    in_result       = $urandom;
    mem_rdata_valid = 1'b0;
    tick();
    // Stall: keep offering junk instructions, none may be taken.
    for (int i = 0; i < nwait; i++) begin
      in_valid   = 1'b1;
      in_is_load = 1'($urandom_range(1));
      in_dest    = ADDR_W'($urandom_range(31));
      in_result  = $urandom;
      in_ld_type = 3'($urandom_range(7));
      in_addr_lo = 2'($urandom_range(3));
      mem_rdata  = $urandom;
      check_quiet("ld.wait", 1'b1);
      tick();
    end
    check_quiet("ld.wait", 1'b1);
    in_valid        = 1'b0;
    mem_rdata_valid = 1'b1;
    mem_rdata       = word;
    tick();
    mem_rdata_valid = 1'b0;
    mem_rdata       = $urandom;
    check_write("ld", dest, ld_model(ld_type, addr, word));
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    in_valid        = 1'b0;
    mem_rdata_valid = 1'b0;
    #1;
    exp_cnt   = 0;
    last_addr = 0;
    last_data = 0;
    check_quiet("rst", 1'b0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    in_valid        = 1'b0;
    in_dest         = '0;
    in_result       = '0;
    in_is_load      = 1'b0;
    in_ld_type      = '0;
    in_addr_lo      = '0;
    mem_rdata_valid = 1'b0;
    mem_rdata       = '0;
    @(negedge clk);
    do_reset();
    idle(2, 1'b0);

    // Reset in the middle of a memory wait discards the held load.
    in_valid   = 1'b1;
    in_is_load = 1'b1;
    in_dest    = 5'd9;
    in_ld_type = 3'd0;
    tick();
    in_valid = 1'b0;
    check_quiet("rstld.wait", 1'b1);
    tick();
    do_reset();
    idle(3, 1'b1);

    // Single non-load.
    send_alu(5, 32'hDEAD_BEEF);
    idle(1, 1'b0);

    // Back-to-back non-loads, then a dest=0 entry that still counts.
    do_reset();
    send_alu(1, 32'h1111_1111);
    send_alu(2, 32'h2222_2222);
    send_alu(3, 32'h3333_3333);
    send_alu(0, 32'h0BAD_0BAD);
    idle(1, 1'b0);

    // Load extraction on a fixed word; the first one stalls four cycles.
    send_load(7, 1, 3, 32'h80FF_7F01, 4);
    check("lb3.val", 64'(wdata), 64'h0000_0000_FFFF_FF80);
    send_load(8, 2, 1, 32'h80FF_7F01, 0);
    send_load(9, 3, 2, 32'h80FF_7F01, 1);
    send_load(10, 4, 0, 32'h80FF_7F01, 2);
    send_load(11, 0, 2, 32'h80FF_7F01, 0);
    send_load(0, 1, 0, 32'h8000_0080, 1);
    send_load(12, 6, 3, 32'hCAFE_F00D, 0);
    idle(1, 1'b0);

    // Random mix of non-loads, loads and idle gaps.
    for (int t = 0; t < 300; t++) begin
      int unsigned sel;
      int unsigned dest;
      sel  = $urandom_range(9);
      dest = ($urandom_range(7) == 0) ? 0 : $urandom_range(31);
      if (sel < 4) begin
        send_alu(dest, $urandom);
      end else if (sel < 8) begin
        send_load(dest, $urandom_range(7), $urandom_range(3), $urandom, $urandom_range(4));
      end else begin
        idle($urandom_range(1, 2), 1'b0);
      end
    end
    idle(1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
